program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 25 ++
 rtl/program_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write bundle for program_loader.
// master drives the stream and observes the memory side; slave is the loader.
interface program_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error, word_count
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error, word_count
  );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  program_loader_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HDR_HI = 3'd1;
  localparam logic [2:0] HDR_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CHK    = 3'd4;
`endif
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  // Where a load ends once the payload is exhausted (or empty).
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] TAIL = CHK;
`else
  localparam logic [2:0] TAIL = DONE;
`endif

  logic [2:0]  state, stateNext;
  logic [7:0]  hdrHi, hdrHiNext;
  logic [15:0] wordTotal, wordTotalNext;
  logic [1:0]  byteOff, byteOffNext;
  logic [23:0] wordBuf, wordBufNext;
  logic [15:0] wordCount, wordCountNext;
  logic        memWe, memWeNext;
  logic [31:0] memAddr, memAddrNext;
  logic [31:0] memData, memDataNext;
  logic        byteReady, byteReadyNext;
  logic        cpuHold, cpuHoldNext;
  logic        doneReg, doneNext;
  logic        errorReg, errorNext;
  logic        accept;
  logic [15:0] hdrTotal;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  checksum, checksumNext;
`endif

  assign accept   = bus.byte_valid && byteReady;
  assign hdrTotal = {hdrHi, bus.byte_in};

  // Next-state and next-output logic.
  always_comb begin
    stateNext     = state;
    hdrHiNext     = hdrHi;
    wordTotalNext = wordTotal;
    byteOffNext   = byteOff;
    wordBufNext   = wordBuf;
    wordCountNext = wordCount;
    memWeNext     = 1'b0;
    memAddrNext   = memAddr;
    memDataNext   = memData;
`ifdef LOADER_CHECKSUM_EN
    checksumNext  = checksum;
`endif

    case (state)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          stateNext     = HDR_HI;
          wordCountNext = 16'd0;
          byteOffNext   = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          checksumNext  = 8'd0;
`endif
        end
      end
      HDR_HI: begin
        if (accept) begin
          hdrHiNext = bus.byte_in;
          stateNext = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          wordTotalNext = hdrTotal;
          byteOffNext   = 2'd0;
          if (hdrTotal == 16'd0)            stateNext = TAIL;
          else if (32'(hdrTotal) > DEPTH)   stateNext = ERR;
          else                              stateNext = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          byteOffNext = byteOff + 2'd1;
          wordBufNext = {wordBuf[15:0], bus.byte_in};
`ifdef LOADER_CHECKSUM_EN
          checksumNext = checksum ^ bus.byte_in;
`endif
          // Fourth byte completes the word; the write strobe follows next cycle.
          if (byteOff == 2'd3) begin
            memWeNext     = 1'b1;
            memAddrNext   = BASE_ADDR + 32'({wordCount, 2'b00});
            memDataNext   = {wordBuf, bus.byte_in};
            wordCountNext = wordCount + 16'd1;
            if (17'(wordCount) + 17'd1 == 17'(wordTotal)) stateNext = TAIL;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) stateNext = (bus.byte_in == checksum) ? DONE : ERR;
      end
`endif
      default: stateNext = IDLE;
    endcase

    byteReadyNext = (stateNext == HDR_HI) || (stateNext == HDR_LO) || (stateNext == DATA)
`ifdef LOADER_CHECKSUM_EN
                    || (stateNext == CHK)
`endif
                    ;
    cpuHoldNext   = (stateNext != IDLE) && (stateNext != DONE);
    doneNext      = (stateNext == DONE);
    errorNext     = (stateNext == ERR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hdrHi     <= 8'd0;
      wordTotal <= 16'd0;
      byteOff   <= 2'd0;
      wordBuf   <= 24'd0;
      wordCount <= 16'd0;
      memWe     <= 1'b0;
      memAddr   <= 32'd0;
      memData   <= 32'd0;
      byteReady <= 1'b0;
      cpuHold   <= 1'b0;
      doneReg   <= 1'b0;
      errorReg  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum  <= 8'd0;
`endif
    end else begin
      state     <= stateNext;
      hdrHi     <= hdrHiNext;
      wordTotal <= wordTotalNext;
      byteOff   <= byteOffNext;
      wordBuf   <= wordBufNext;
      wordCount <= wordCountNext;
      memWe     <= memWeNext;
      memAddr   <= memAddrNext;
      memData   <= memDataNext;
      byteReady <= byteReadyNext;
      cpuHold   <= cpuHoldNext;
      doneReg   <= doneNext;
      errorReg  <= errorNext;
`ifdef LOADER_CHECKSUM_EN
      checksum  <= checksumNext;
`endif
    end
  end

  assign bus.byte_ready = byteReady;
  assign bus.mem_we     = memWe;
  assign bus.mem_addr   = memAddr;
  assign bus.mem_data   = memData;
  assign bus.cpu_hold   = cpuHold;
  assign bus.done       = doneReg;
  assign bus.error      = errorReg;
  assign bus.word_count = wordCount;

endmodule
